arcade_input_mapper: RTL and testbench

Generalised player-input front end for arcade cores. It decodes PS/2 key events through a runtime-loadable keymap and merges the result with per-player HPS joystick words. It then applies one of four screen-rotation remaps and generates fixed-length coin pulses from start presses. It sits between hps_io and the game core, replacing per-core hard-coded keyboard case statements.

---
 rtl/arcade_input_mapper.sv | 207 ++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 keymap scan merged with HPS joysticks, screen rotation and coin pulses.
// Optional autofire on fire bit 4 is compiled in with `define AUTOFIRE_EN.
//   state  | meaning
//   S_IDLE | waiting for a key event
//   S_SCAN | walking keymap entries 0..E-1, one per cycle
module arcade_input_mapper #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BTN      = 8,
    parameter int START_BIT    = 5,
    parameter int COIN_CYCLES  = 16,
    parameter int AUTOFIRE_DIV = 1048576
) (
    input  logic                                   clk_sys,
    input  logic                                   reset_n,
    input  logic [10:0]                            ps2_key,
    input  logic [NUM_PLAYERS*16-1:0]              joy_in,
    input  logic                                   joy_share,
    input  logic [1:0]                             rot,
    input  logic                                   map_wr,
    input  logic [$clog2(NUM_PLAYERS*NUM_BTN)-1:0] map_addr,
    input  logic [9:0]                             map_data,
    output logic [NUM_PLAYERS*NUM_BTN-1:0]         btn_out,
    output logic [NUM_PLAYERS-1:0]                 coin_out,
    output logic                                   busy,
    output logic                                   key_drop
);
    localparam int E  = NUM_PLAYERS * NUM_BTN;
    localparam int AW = $clog2(E);
    localparam int CW = $clog2(COIN_CYCLES + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic          primed, prev_toggle, new_event;
    logic [0:0]    state;
    logic [AW-1:0] idx;
    logic          last;
    logic [9:0]    ev, pend;
    logic          pend_valid;
    logic [9:0]    keymap [E];
    logic [E-1:0]  key_state;
    logic [E-1:0]  mapped;
    logic [15:0]   joy_or;

    // The tracker samples the live toggle on the first cycle after reset so no event is invented.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed      <= 1'b0;
            prev_toggle <= 1'b0;
        end else begin
            primed      <= 1'b1;
            prev_toggle <= ps2_key[10];
        end
    end

    assign new_event = primed && (ps2_key[10] != prev_toggle);
    assign last      = (idx == AW'(E - 1));
    assign busy      = (state == S_SCAN);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            ev         <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            key_drop   <= 1'b0;
        end else if (state == S_IDLE) begin
            if (new_event) begin
                ev    <= ps2_key[9:0];
                idx   <= '0;
                state <= S_SCAN;
            end
        end else if (last) begin
            idx <= '0;
            if (pend_valid) begin
                ev         <= pend;
                pend       <= ps2_key[9:0];
                pend_valid <= new_event;
            end else if (new_event) begin
                ev <= ps2_key[9:0];
            end else begin
                state <= S_IDLE;
            end
        end else begin
            idx <= idx + 1'b1;
            if (new_event) begin
                if (pend_valid) begin
                    key_drop <= 1'b1;
                end else begin
                    pend       <= ps2_key[9:0];
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    // A keymap write is ordered after the scan update so it wins on the same entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < E; e++) keymap[e] <= '0;
            key_state <= '0;
        end else begin
            if (state == S_SCAN && keymap[idx][9] && keymap[idx][8:0] == ev[8:0])
                key_state[idx] <= ev[9];
            if (map_wr && (32'(map_addr) < E)) begin
                keymap[map_addr]    <= map_data;
                key_state[map_addr] <= 1'b0;
            end
        end
    end

    always_comb begin
        joy_or = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) joy_or = joy_or | joy_in[16*p +: 16];
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [15:0]        jw;
        logic               unused_jw;
        logic [NUM_BTN-1:0] mv, rv, fv;
        logic               start_d;
        logic [CW-1:0]      coin_cnt;

        assign jw        = joy_share ? joy_or : joy_in[16*p +: 16];
        assign unused_jw = ^jw;
        assign mv        = key_state[p*NUM_BTN +: NUM_BTN] | jw[NUM_BTN-1:0];

        // Bits 0..3 are R,L,D,U.
        always_comb begin
            rv = mv;
            case (rot)
                2'd1: begin rv[3] = mv[1]; rv[2] = mv[0]; rv[1] = mv[2]; rv[0] = mv[3]; end
                2'd2: begin rv[3] = mv[2]; rv[2] = mv[3]; rv[1] = mv[0]; rv[0] = mv[1]; end
                2'd3: begin rv[3] = mv[0]; rv[2] = mv[1]; rv[1] = mv[3]; rv[0] = mv[2]; end
                default: rv = mv;
            endcase
        end

`ifdef AUTOFIRE_EN
        if (NUM_BTN > 4) begin : g_af
            localparam int AFW = $clog2(AUTOFIRE_DIV + 1);
            localparam logic [AFW-1:0] AF_RELOAD = AFW'(AUTOFIRE_DIV - 1);
            localparam logic [AFW-1:0] AF_FIRST  = AFW'((AUTOFIRE_DIV > 1) ? AUTOFIRE_DIV - 2 : 0);
            logic           fire_d, phase;
            logic [AFW-1:0] af_cnt;

            // The rising-edge cycle counts as the first "on" cycle of the half-period.
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    fire_d <= 1'b0;
                    phase  <= 1'b1;
                    af_cnt <= '0;
                end else begin
                    fire_d <= rv[4];
                    if (rv[4] && !fire_d) begin
                        phase  <= (AUTOFIRE_DIV > 1);
                        af_cnt <= AF_FIRST;
                    end else if (rv[4]) begin
                        if (af_cnt == '0) begin
                            phase  <= ~phase;
                            af_cnt <= AF_RELOAD;
                        end else begin
                            af_cnt <= af_cnt - 1'b1;
                        end
                    end
                end
            end

            always_comb begin
                fv    = rv;
                fv[4] = rv[4] & (phase | ~fire_d);
            end
        end else begin : g_no_af
            assign fv = rv;
        end
`else
        assign fv = rv;
`endif

        assign mapped[p*NUM_BTN +: NUM_BTN] = fv;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                start_d  <= 1'b0;
                coin_cnt <= '0;
            end else begin
                start_d <= btn_out[p*NUM_BTN + START_BIT];
                if (coin_cnt != '0)
                    coin_cnt <= coin_cnt - 1'b1;
                else if (btn_out[p*NUM_BTN + START_BIT] && !start_d)
                    coin_cnt <= CW'(COIN_CYCLES);
            end
        end

        assign coin_out[p] = (coin_cnt != '0);
    end

`ifndef AUTOFIRE_EN
    logic unused_af;
    assign unused_af = (AUTOFIRE_DIV != 0);
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) btn_out <= '0;
        else          btn_out <= mapped;
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: directed timing checks plus randomized keymap/joystick traffic.
module tb_arcade_input_mapper;
    localparam int NP = 2;
    localparam int NB = 8;
    localparam int E  = NP * NB;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joy_in;
    logic        joy_share;
    logic [1:0]  rot;
    logic        map_wr;
    logic [3:0]  map_addr;
    logic [9:0]  map_data;
    logic [15:0] btn_out;
    logic [1:0]  coin_out;
    logic        busy;
    logic        key_drop;

    arcade_input_mapper dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
        .joy_share(joy_share), .rot(rot), .map_wr(map_wr), .map_addr(map_addr),
        .map_data(map_data), .btn_out(btn_out), .coin_out(coin_out), .busy(busy),
        .key_drop(key_drop)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;
    logic tog = 1'b1;
    logic [9:0] mk [E];
    logic       ks [E];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < E; e++) begin
            mk[e] = '0;
            ks[e] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        model_clear();
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic wr(input int a, input logic [9:0] d);
        map_wr   = 1'b1;
        map_addr = 4'(a);
        map_data = d;
        tick(1);
        map_wr = 1'b0;
        mk[a]  = d;
        ks[a]  = 1'b0;
    endtask

    task automatic key_drive(input logic p, input logic x, input logic [7:0] c);
        tog     = ~tog;
        ps2_key = {tog, p, x, c};
    endtask

    task automatic model_event(input logic p, input logic x, input logic [7:0] c);
        for (int e = 0; e < E; e++)
            if (mk[e][9] && mk[e][8:0] == {x, c}) ks[e] = p;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        check("scan_end_timeout", 32'(busy), 0);
    endtask

    // Directions sit on a clockwise circle U,R,D,L; rotation by r takes each output from r steps back.
    function automatic logic [15:0] exp_btn();
        logic [15:0]   o;
        logic [15:0]   j;
        logic [NB-1:0] m, r;
        int circ [4] = '{3, 0, 2, 1};
        o = '0;
        for (int p = 0; p < NP; p++) begin
            j = joy_share ? (joy_in[15:0] | joy_in[31:16]) : joy_in[16*p +: 16];
            for (int b = 0; b < NB; b++) m[b] = ks[p*NB + b] | j[b];
            r = m;
            for (int i = 0; i < 4; i++) r[circ[i]] = m[circ[(i - int'(rot) + 4) % 4]];
            o[p*NB +: NB] = r;
        end
        return o;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, g, hi0, hi1, sel;
        int rt [4] = '{3, 0, 2, 1};
        logic [7:0] codes [4] = '{8'h29, 8'h16, 8'h1E, 8'h25};
        logic p, x;
        logic [7:0] c;

        reset_n   = 1'b0;
        ps2_key   = 11'h400;
        joy_in    = '0;
        joy_share = 1'b0;
        rot       = 2'd0;
        map_wr    = 1'b0;
        map_addr  = '0;
        map_data  = '0;
        model_clear();
        tick(2);
        check("rst_btn", 32'(btn_out), 0);
        check("rst_coin", 32'(coin_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop", 32'(key_drop), 0);
        reset_n = 1'b1;
        n = 0;
        repeat (100) begin
            tick(1);
            if (busy) n++;
        end
        check("no_spurious_scan", n, 0);
        check("idle_btn", 32'(btn_out), 0);

        // Single mapped key, latency T+7 for entry 4
        wr(4, 10'h229);
        key_drive(1'b1, 1'b0, 8'h29);
        tick(6);
        check("press_lat_t6", 32'(btn_out[4]), 0);
        tick(1);
        check("press_lat_t7", 32'(btn_out[4]), 1);
        model_event(1'b1, 1'b0, 8'h29);
        wait_idle();
        key_drive(1'b0, 1'b0, 8'h29);
        tick(6);
        check("release_lat_t6", 32'(btn_out[4]), 1);
        tick(1);
        check("release_lat_t7", 32'(btn_out[4]), 0);
        model_event(1'b0, 1'b0, 8'h29);
        wait_idle();
        tick(2);
        check("after_release", 32'(btn_out), 32'(exp_btn()));

        // Two entries share a code; scan length
        wr(12, 10'h229);
        key_drive(1'b1, 1'b0, 8'h29);
        tick(1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick(1);
        end
        check("busy_len", n, 16);
        model_event(1'b1, 1'b0, 8'h29);
        tick(2);
        check("dup_map", 32'({btn_out[12], btn_out[4]}), 32'h3);
        check("dup_map_all", 32'(btn_out), 32'(exp_btn()));

        // Three back-to-back events: one scanned, one pending, one dropped
        wr(0, 10'h216);
        wr(1, 10'h21E);
        n = 0;
        key_drive(1'b1, 1'b0, 8'h16);
        tick(1);
        if (busy) n++;
        key_drive(1'b1, 1'b0, 8'h1E);
        tick(1);
        if (busy) n++;
        key_drive(1'b0, 1'b0, 8'h29);
        tick(1);
        if (busy) n++;
        g = 0;
        while (busy && g < 200) begin
            tick(1);
            g++;
            if (busy) n++;
        end
        check("two_scans_busy", n, 32);
        model_event(1'b1, 1'b0, 8'h16);
        model_event(1'b1, 1'b0, 8'h1E);
        tick(2);
        check("drop_btn", 32'(btn_out), 32'(exp_btn()));
        check("drop_flag", 32'(key_drop), 1);
        tick(50);
        check("drop_sticky", 32'(key_drop), 1);
        do_reset();
        check("drop_cleared", 32'(key_drop), 0);
        check("reset_btn", 32'(btn_out), 0);

        // Rotation of P1 up
        joy_in = 32'h8;
        for (int r = 0; r < 4; r++) begin
            rot = 2'(r);
            tick(2);
            check($sformatf("rot_%0d", r), 32'(btn_out), 32'(16'(1) << rt[r]));
        end
        rot       = 2'd0;
        joy_share = 1'b1;
        joy_in    = 32'h0008_0000;
        tick(2);
        check("share", 32'(btn_out), 32'h0808);
        joy_in    = '0;
        joy_share = 1'b0;
        tick(2);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                wr($urandom_range(0, E - 1),
                   {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), codes[$urandom_range(0, 3)]});
                tick(2);
            end else if (sel == 1) begin
                p = 1'($urandom_range(0, 1));
                x = 1'($urandom_range(0, 1));
                c = codes[$urandom_range(0, 3)];
                key_drive(p, x, c);
                tick(1);
                model_event(p, x, c);
                wait_idle();
                tick(2);
            end else begin
                joy_in    = $urandom;
                joy_share = 1'($urandom_range(0, 1));
                rot       = 2'($urandom_range(0, 3));
                tick(2);
            end
            check($sformatf("rand_%0d", it), 32'(btn_out), 32'(exp_btn()));
        end

        // Coin pulses
        joy_in    = '0;
        joy_share = 1'b0;
        rot       = 2'd0;
        do_reset();
        tick(2);
        joy_in = 32'h20;
        tick(1);
        check("coin_btn", 32'(btn_out[5]), 1);
        check("coin_not_yet", 32'(coin_out[0]), 0);
        tick(1);
        check("coin_start", 32'(coin_out[0]), 1);
        hi0 = 1;
        hi1 = 0;
        for (int i = 0; i < 40; i++) begin
            joy_in = (i == 3 || i == 4) ? 32'h20 : 32'h0;
            tick(1);
            if (coin_out[0]) hi0++;
            if (coin_out[1]) hi1++;
        end
        check("coin_len", hi0, 16);
        check("coin_other", hi1, 0);
        joy_in = 32'h0020_0000;
        tick(2);
        check("coin_p1", 32'(coin_out), 32'h2);
        joy_in = 32'h0;
        tick(20);
        joy_in = 32'h20;
        tick(5);
        check("coin_mid", 32'(coin_out[0]), 1);
        reset_n = 1'b0;
        #1;
        check("coin_async_clear", 32'(coin_out), 0);
        joy_in = '0;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        check("coin_after_reset", 32'(coin_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
